gmii_stats_axil_slave: RTL and testbench

AXI4-Lite responder sitting behind the PS interconnect at each GMII mux base address (e.g. 0xA0200000). It holds the mux control register that selects the traffic-generator path and counts good RX and TX frames on the muxed GMII port. It answers the PS master's `read_data`/`write_data` transactions, so software and simulation benches can enable the generator and check frame counts without a MAC statistics block.

---
 rtl/gmii_stats_pkg.sv | 14 +
 rtl/gmii_frame_counter.sv | 28 ++
 rtl/gmii_stats_axil_slave.sv | 127 ++++++++++++
 tb/tb_gmii_stats_axil_slave.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_stats_pkg.sv
// gmii_stats_pkg: register offsets, default ID, AXI response codes and FSM state types shared by the GMII stats slave
package gmii_stats_pkg;
  localparam logic [31:0] DEFAULT_ID = 32'h474D5558;
  localparam logic [31:0] OFF_ID     = 32'h00;
  localparam logic [31:0] OFF_CTRL   = 32'h08;
  localparam logic [31:0] OFF_RX_LO  = 32'h10;
  localparam logic [31:0] OFF_RX_HI  = 32'h14;
  localparam logic [31:0] OFF_TX_LO  = 32'h18;
  localparam logic [31:0] OFF_TX_HI  = 32'h1C;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_e;
endpackage

// File: rtl/gmii_frame_counter.sv
// gmii_frame_counter: counts error-free frames (en span with er never high); ports clk, rst, en_i, er_i, clr_i -> count_o
module gmii_frame_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 er_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o
);
  logic in_q, err_q, err_d, good;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  assign err_d   = en_i & (er_i | (in_q & err_q));
  assign good    = in_q & ~en_i & ~err_q;
  assign count_d = clr_i ? '0 : good ? count_q + CNT_WIDTH'(1) : count_q;
  assign count_o = count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_q    <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      in_q    <= en_i;
      err_q   <= err_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/gmii_stats_axil_slave.sv
// gmii_stats_axil_slave: AXI4-Lite slave with ID, CTRL (mux_sel, counter clear) and coherent 64-bit RX/TX good-frame counters; ports AXI-Lite s_axi_*, GMII strobes, mux_sel
module gmii_stats_axil_slave
  import gmii_stats_pkg::*;
#(
  parameter int          C_S_AXI_ADDR_WIDTH = 16,
  parameter logic [31:0] ID_VALUE           = DEFAULT_ID,
  parameter int          CNT_WIDTH          = 64
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic                          gmii_rx_dv,
  input  logic                          gmii_rx_er,
  input  logic                          gmii_tx_en,
  input  logic                          gmii_tx_er,
  output logic [1:0]                    mux_sel
);
  w_state_e w_q;
  r_state_e r_q;
  logic [31:0] waddr, raddr, rd;
  logic w_map, r_map, clr;
  logic [CNT_WIDTH-1:0] rx_cnt, tx_cnt;
  logic [CNT_WIDTH-33:0] rx_shd_q, tx_shd_q;
  assign waddr = 32'(s_axi_awaddr);
  assign raddr = 32'(s_axi_araddr);
  assign w_map = waddr inside {OFF_ID, OFF_CTRL, OFF_RX_LO, OFF_RX_HI, OFF_TX_LO, OFF_TX_HI};
  assign r_map = raddr inside {OFF_ID, OFF_CTRL, OFF_RX_LO, OFF_RX_HI, OFF_TX_LO, OFF_TX_HI};
  assign clr   = (w_q == W_ACK) && (waddr == OFF_CTRL) && s_axi_wstrb[3] && s_axi_wdata[31];
  // high words come from the shadow captured at the last low-word read
  assign rd = raddr == OFF_ID    ? ID_VALUE :
              raddr == OFF_CTRL  ? {30'h0, mux_sel} :
              raddr == OFF_RX_LO ? rx_cnt[31:0] :
              raddr == OFF_RX_HI ? 32'(rx_shd_q) :
              raddr == OFF_TX_LO ? tx_cnt[31:0] :
              raddr == OFF_TX_HI ? 32'(tx_shd_q) : 32'h0;
  gmii_frame_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rx (
    .clk(aclk), .rst(areset), .en_i(gmii_rx_dv), .er_i(gmii_rx_er), .clr_i(clr), .count_o(rx_cnt)
  );
  gmii_frame_counter #(.CNT_WIDTH(CNT_WIDTH)) u_tx (
    .clk(aclk), .rst(areset), .en_i(gmii_tx_en), .er_i(gmii_tx_er), .clr_i(clr), .count_o(tx_cnt)
  );
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      w_q           <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      mux_sel       <= 2'd0;
    end else begin
      case (w_q)
        W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
          w_q           <= W_ACK;
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b1;
        end
        W_ACK: begin
          w_q           <= W_RESP;
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b0;
          s_axi_bvalid  <= 1'b1;
          s_axi_bresp   <= w_map ? RESP_OKAY : RESP_SLVERR;
          if (waddr == OFF_CTRL && s_axi_wstrb[0]) mux_sel <= s_axi_wdata[1:0];
        end
        W_RESP: if (s_axi_bready) begin
          w_q          <= W_IDLE;
          s_axi_bvalid <= 1'b0;
        end
        default: w_q <= W_IDLE;
      endcase
    end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_q           <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 32'h0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_q)
        R_IDLE: if (s_axi_arvalid) begin
          r_q           <= R_ACK;
          s_axi_arready <= 1'b1;
        end
        R_ACK: begin
          r_q           <= R_DATA;
          s_axi_arready <= 1'b0;
          s_axi_rvalid  <= 1'b1;
          s_axi_rdata   <= rd;
          s_axi_rresp   <= r_map ? RESP_OKAY : RESP_SLVERR;
        end
        R_DATA: if (s_axi_rready) begin
          r_q          <= R_IDLE;
          s_axi_rvalid <= 1'b0;
        end
        default: r_q <= R_IDLE;
      endcase
    end
  // clear beats a same-cycle low-word snapshot
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      rx_shd_q <= '0;
      tx_shd_q <= '0;
    end else if (clr) begin
      rx_shd_q <= '0;
      tx_shd_q <= '0;
    end else if (r_q == R_ACK) begin
      if (raddr == OFF_RX_LO) rx_shd_q <= rx_cnt[CNT_WIDTH-1:32];
      if (raddr == OFF_TX_LO) tx_shd_q <= tx_cnt[CNT_WIDTH-1:32];
    end
endmodule

// File: tb/tb_gmii_stats_axil_slave.sv
// tb_gmii_stats_axil_slave: directed + randomized frame traffic against a frame-list model, checked with immediate assertions
module tb_gmii_stats_axil_slave;
  logic clk = 1'b0, areset;
  logic [15:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp, mux_sel;
  logic rx_dv, rx_er, tx_en, tx_er;
  int checks = 0, fails = 0;
  logic [63:0] rx_m, tx_m, snap_m;
  logic [1:0] ms_m, ms_at_ack, ms_at_b;
  logic [31:0] d;
  logic [1:0] r;
  int lat;
  logic [63:0] v;

  always #5 clk = ~clk;

  gmii_stats_axil_slave dut (
    .aclk(clk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .gmii_rx_dv(rx_dv), .gmii_rx_er(rx_er), .gmii_tx_en(tx_en), .gmii_tx_er(tx_er),
    .mux_sel(mux_sel)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] dat, input logic [3:0] s,
                           output logic [1:0] resp, output int l);
    l = -1;
    resp = 2'bxx;
    ms_at_b = 2'bxx;
    @(negedge clk);
    awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin l = i; break; end
    end
    ms_at_ack = mux_sel;
    if (l < 0) begin awvalid = 1'b0; wvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin resp = bresp; ms_at_b = mux_sel; break; end
      @(negedge clk);
    end
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] dat, output logic [1:0] resp, output int l);
    l = -1;
    dat = 'x;
    resp = 2'bxx;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (arready) begin l = i; break; end
    end
    if (l < 0) begin arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin dat = rdata; resp = rresp; break; end
      @(negedge clk);
    end
  endtask

  task automatic read_cnt(input logic [15:0] lo, output logic [63:0] val);
    logic [31:0] a, b;
    logic [1:0] ra, rb;
    int l;
    axi_read(lo, a, ra, l);
    axi_read(lo + 16'h4, b, rb, l);
    val = {b, a};
  endtask

  // one frame of len cycles, er at cycle err_at (negative = clean), then a gap that may carry a stray er
  task automatic frame(input bit tx, input int len, input int err_at);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (tx) begin tx_en = 1'b1; tx_er = (i == err_at); end
      else begin rx_dv = 1'b1; rx_er = (i == err_at); end
    end
    @(negedge clk);
    rx_dv = 1'b0; rx_er = 1'b0; tx_en = 1'b0; tx_er = 1'b0;
    if ($urandom_range(0, 1) == 1) begin
      if (tx) tx_er = 1'b1; else rx_er = 1'b1;
      @(negedge clk);
      rx_er = 1'b0; tx_er = 1'b0;
    end
    @(negedge clk);
    if (err_at < 0) begin
      if (tx) tx_m++; else rx_m++;
    end
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    rx_dv = 0; rx_er = 0; tx_en = 0; tx_er = 0;
    rx_m = '0; tx_m = '0; ms_m = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, mux_sel}, '0);
    areset = 1'b0;

    axi_read(16'h00, d, r, lat);
    check("id_data", d, 32'h474D5558);
    check("id_resp", r, 2'b00);
    check("rd_latency", lat, 1);
    axi_read(16'h08, d, r, lat);
    check("ctrl_reset", d, 0);

    axi_write(16'h08, 32'h2, 4'hF, r, lat);
    ms_m = 2'd2;
    check("wr_latency", lat, 1);
    check("ctrl_bresp", r, 2'b00);
    check("mux_at_ack", ms_at_ack, 2'd0);
    check("mux_at_bvalid", ms_at_b, ms_m);
    axi_read(16'h08, d, r, lat);
    check("ctrl_readback", d, {30'h0, ms_m});
    axi_write(16'h08, 32'h1, 4'h0, r, lat);
    check("strb0_resp", r, 2'b00);
    check("strb0_mux", mux_sel, ms_m);
    axi_write(16'h08, 32'h1, 4'h1, r, lat);
    ms_m = 2'd1;
    check("strb1_mux", mux_sel, ms_m);
    axi_write(16'h08, 32'h2, 4'h1, r, lat);
    ms_m = 2'd2;
    axi_write(16'h00, 32'h0, 4'hF, r, lat);
    check("ro_write_resp", r, 2'b00);
    axi_read(16'h00, d, r, lat);
    check("ro_write_kept", d, 32'h474D5558);
    axi_write(16'h40, 32'h3, 4'hF, r, lat);
    check("bad_wr_resp", r, 2'b10);
    check("bad_wr_mux", mux_sel, ms_m);
    axi_read(16'h40, d, r, lat);
    check("bad_rd_resp", r, 2'b10);
    check("bad_rd_data", d, 0);

    frame(1'b0, 64, -1);
    frame(1'b0, 64, 10);
    frame(1'b0, 64, -1);
    for (int k = 0; k < 5; k++) frame(1'b1, 64, -1);
    read_cnt(16'h10, v);
    check("rx_directed", v, 64'd2);
    read_cnt(16'h18, v);
    check("tx_directed", v, 64'd5);

    for (int k = 0; k < 40; k++) begin
      int len, ea;
      len = int'($urandom_range(1, 12));
      ea = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      frame(1'($urandom_range(0, 1)), len, ea);
    end
    read_cnt(16'h10, v);
    check("rx_random", v, rx_m);
    read_cnt(16'h18, v);
    check("tx_random", v, tx_m);

    @(negedge clk);
    force dut.u_rx.count_q = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    release dut.u_rx.count_q;
    rx_m = 64'h0000_0000_FFFF_FFFF;
    axi_read(16'h10, d, r, lat);
    snap_m = rx_m;
    check("wrap32_lo", d, snap_m[31:0]);
    frame(1'b0, 4, -1);
    axi_read(16'h14, d, r, lat);
    check("snapshot_hi", d, snap_m[63:32]);
    read_cnt(16'h10, v);
    check("fresh_pair", v, rx_m);

    @(negedge clk);
    force dut.u_rx.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.u_rx.count_q;
    rx_m = 64'hFFFF_FFFF_FFFF_FFFF;
    frame(1'b0, 3, -1);
    read_cnt(16'h10, v);
    check("wrap64", v, rx_m);
    frame(1'b0, 5, -1);

    @(negedge clk);
    rx_dv = 1'b1; tx_en = 1'b1;
    repeat (5) @(negedge clk);
    awaddr = 16'h08; wdata = 32'h8000_0000; wstrb = 4'h8; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    check("clr_awready", awready, 1'b1);
    rx_dv = 1'b0; tx_en = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("clr_bvalid", {bvalid, bresp}, 3'b100);
    rx_m = '0; tx_m = '0;
    axi_read(16'h14, d, r, lat);
    check("clr_shadow", d, 0);
    read_cnt(16'h10, v);
    check("clr_rx", v, rx_m);
    read_cnt(16'h18, v);
    check("clr_tx", v, tx_m);
    check("clr_mux_kept", mux_sel, ms_m);
    axi_read(16'h08, d, r, lat);
    check("clr_reads0", d, {30'h0, ms_m});

    @(negedge clk);
    bready = 1'b0;
    awaddr = 16'h00; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("bp_awready", awready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_bvalid_held", bvalid, 1'b1);
      check("bp_no_accept", awready, 1'b0);
    end
    bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bp_bvalid_drop", bvalid, 1'b0);

    rready = 1'b0;
    araddr = 16'h00; arvalid = 1'b1;
    @(negedge clk);
    check("rbp_arready", arready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rbp_rvalid_held", rvalid, 1'b1);
      check("rbp_no_accept", arready, 1'b0);
    end
    check("rbp_data", rdata, 32'h474D5558);
    rready = 1'b1; arvalid = 1'b0;
    @(negedge clk);
    check("rbp_rvalid_drop", rvalid, 1'b0);

    rready = 1'b0;
    araddr = 16'h08; arvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rst_pre_rvalid", rvalid, 1'b1);
    #2 areset = 1'b1;
    #1 check("rst_rvalid_drop", {rvalid, rdata, arready}, '0);
    @(negedge clk);
    areset = 1'b0;
    rx_m = '0; tx_m = '0; ms_m = 2'd0;
    check("rst_mux", mux_sel, ms_m);
    repeat (3) @(negedge clk);
    check("rst_no_resp", rvalid, 1'b0);
    read_cnt(16'h10, v);
    check("rst_rx", v, rx_m);
    axi_read(16'h00, d, r, lat);
    check("post_rst_id", d, 32'h474D5558);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
